// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-timer sequencer.
package reaction_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_DELAY   = 3'd1,
      S_MEASURE = 3'd2,
      S_RESULT  = 3'd3,
      S_FOUL    = 3'd4
   } state_t;

   localparam logic [15:0] BCD_MAX           = 16'h9999;
   localparam logic [15:0] LFSR_TAPS         = 16'hB400;  // taps 16,14,13,11
   localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

   function automatic logic [15:0] lfsr_next(input logic [15:0] q);
      return {q[14:0], ^(q & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; an all-zero seed would lock up, so it is substituted.
module lfsr16
   import reaction_pkg::*;
#(
   parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
   input  logic        CLK,
   input  logic        RST,
   output logic [15:0] q
);

   localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? LFSR_DEFAULT_SEED : SEED;

   always_ff @(posedge CLK) begin
      if (RST) q <= SEED_EFF;
      else     q <= lfsr_next(q);
   end

endmodule

// File: rtl/reaction_sequencer.sv
// Reaction-timer game controller: random pre-stimulus delay, measurement, best-time tracking.
//
//  state     | meaning
//  ----------+--------------------------------------------------------------
//  S_IDLE    | timer held cleared, waiting for start press (unless locked)
//  S_DELAY   | counting down random ms delay; stop press here is a foul
//  S_MEASURE | lamp on, timer counting until stop press or MAX_RT
//  S_RESULT  | timer frozen, best time updated on second cycle
//  S_FOUL    | false start shown, timer held cleared
module reaction_sequencer
   import reaction_pkg::*;
#(
   parameter int unsigned DELAY_MIN_MS = 1000,
   parameter int unsigned SPAN_BITS    = 10,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1,
   parameter logic [15:0] MAX_RT       = 16'h9999
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        KEY_START_N,
   input  logic        KEY_STOP_N,
   input  logic        SW_LOCK,
   input  logic        TICK_MS,
   input  logic [15:0] TIMER_VAL,
   output logic        TIMER_CLR,
   output logic        TIMER_EN,
   output logic        LED,
   output logic [15:0] BEST_MS,
   output logic        NEW_BEST,
   output logic        FOUL,
   output logic        TIMEOUT,
   output logic [2:0]  STATE
);

   localparam logic [16:0] SPAN_MASK = 17'((17'd1 << SPAN_BITS) - 17'd1);
   localparam logic [16:0] DELAY_MIN = 17'(DELAY_MIN_MS);

   state_t      state_q, state_d;
   logic [15:0] lfsr_q;
   logic [16:0] dcnt_q;
   logic [16:0] delay_load;
   logic        start_prev_q, stop_prev_q;
   logic        start_press, stop_press;
   logic        res_first_q, res_cmp_q;
   logic        foul_q, timeout_q, new_best_q;
   logic [15:0] best_q;
   logic        at_max;

   lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .CLK (CLK),
      .RST (RST),
      .q   (lfsr_q)
   );

   assign start_press = start_prev_q & ~KEY_START_N;
   assign stop_press  = stop_prev_q  & ~KEY_STOP_N;
   assign delay_load  = DELAY_MIN + ({1'b0, lfsr_q} & SPAN_MASK);
   assign at_max      = (TIMER_VAL == MAX_RT);

   always_ff @(posedge CLK) begin
      if (RST) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (start_press && !SW_LOCK) state_d = S_DELAY;
         // a stop press outranks the final tick
         S_DELAY:   if (stop_press)                         state_d = S_FOUL;
                    else if (TICK_MS && dcnt_q <= 17'd1)    state_d = S_MEASURE;
         S_MEASURE: if (at_max || stop_press)               state_d = S_RESULT;
         S_RESULT:  if (start_press)                        state_d = S_IDLE;
         S_FOUL:    if (start_press)                        state_d = S_IDLE;
         default:                                           state_d = S_IDLE;
      endcase
   end

   always_comb begin
      TIMER_CLR = 1'b0;
      TIMER_EN  = 1'b0;
      LED       = 1'b0;
      case (state_q)
         S_IDLE, S_FOUL: TIMER_CLR = 1'b1;
         S_MEASURE: begin
            TIMER_EN = 1'b1;
            LED      = 1'b1;
         end
         default: ;
      endcase
   end

   // the compare waits one extra RESULT cycle so the last tick settles in the timer
   always_ff @(posedge CLK) begin
      if (RST) begin
         start_prev_q <= 1'b1;
         stop_prev_q  <= 1'b1;
         dcnt_q       <= '0;
         res_first_q  <= 1'b0;
         res_cmp_q    <= 1'b0;
         foul_q       <= 1'b0;
         timeout_q    <= 1'b0;
         new_best_q   <= 1'b0;
         best_q       <= BCD_MAX;
      end else begin
         start_prev_q <= KEY_START_N;
         stop_prev_q  <= KEY_STOP_N;
         res_first_q  <= (state_q == S_MEASURE) && (state_d == S_RESULT);
         res_cmp_q    <= res_first_q;

         if (state_q == S_IDLE && state_d == S_DELAY) begin
            dcnt_q     <= delay_load;
            foul_q     <= 1'b0;
            timeout_q  <= 1'b0;
            new_best_q <= 1'b0;
         end else if (state_q == S_DELAY && TICK_MS && dcnt_q != 17'd0) begin
            dcnt_q <= dcnt_q - 17'd1;
         end

         if (state_q == S_DELAY && state_d == S_FOUL) foul_q <= 1'b1;
         if (state_q == S_MEASURE && at_max)          timeout_q <= 1'b1;

         if (res_cmp_q && state_q == S_RESULT && !timeout_q && TIMER_VAL < best_q) begin
            best_q     <= TIMER_VAL;
            new_best_q <= 1'b1;
         end
      end
   end

   assign BEST_MS  = best_q;
   assign NEW_BEST = new_best_q;
   assign FOUL     = foul_q;
   assign TIMEOUT  = timeout_q;
   assign STATE    = state_q;

endmodule

// File: tb/tb_reaction_sequencer.sv
// Directed bench for reaction_sequencer: short-delay instance for sequencing, default instance for delay range.
module tb_reaction_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // instance 1: DELAY_MIN_MS=4, no random span, so every delay is exactly 4 ticks
   logic        k_start_n = 1'b1, k_stop_n = 1'b1, sw_lock = 1'b0, tick = 1'b0;
   logic        force_en = 1'b0;
   logic [15:0] force_val = 16'h0000;
   logic [15:0] tv = 16'h0000;
   logic [15:0] timer_val;
   logic        t_clr, t_en, led, new_best, foul, timeout;
   logic [15:0] best;
   logic [2:0]  state;

   // instance 2: default parameters, tick every cycle
   logic        s2_start_n = 1'b1, s2_stop_n = 1'b1;
   logic        t2_clr, t2_en, led2, new_best2, foul2, timeout2;
   logic [15:0] best2;
   logic [2:0]  state2;

   int led_cnt = 0, en_cnt = 0;

   assign timer_val = force_en ? force_val : tv;

   reaction_sequencer #(.DELAY_MIN_MS(4), .SPAN_BITS(0)) dut (
      .CLK(clk), .RST(rst), .KEY_START_N(k_start_n), .KEY_STOP_N(k_stop_n),
      .SW_LOCK(sw_lock), .TICK_MS(tick), .TIMER_VAL(timer_val),
      .TIMER_CLR(t_clr), .TIMER_EN(t_en), .LED(led), .BEST_MS(best),
      .NEW_BEST(new_best), .FOUL(foul), .TIMEOUT(timeout), .STATE(state)
   );

   reaction_sequencer dut2 (
      .CLK(clk), .RST(rst), .KEY_START_N(s2_start_n), .KEY_STOP_N(s2_stop_n),
      .SW_LOCK(1'b0), .TICK_MS(1'b1), .TIMER_VAL(16'h0000),
      .TIMER_CLR(t2_clr), .TIMER_EN(t2_en), .LED(led2), .BEST_MS(best2),
      .NEW_BEST(new_best2), .FOUL(foul2), .TIMEOUT(timeout2), .STATE(state2)
   );

   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (c) begin
            if (r[i*4 +: 4] == 4'd9) r[i*4 +: 4] = 4'd0;
            else begin
               r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // external BCD timer model
   always @(posedge clk) begin
      if (t_clr)             tv <= 16'h0000;
      else if (t_en && tick) tv <= bcd_inc(tv);
   end

   always @(posedge clk) begin
      if (led)  led_cnt <= led_cnt + 1;
      if (t_en) en_cnt  <= en_cnt + 1;
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic press_start();
      k_start_n = 1'b0; cyc(); k_start_n = 1'b1;
   endtask

   task automatic press_stop();
      k_stop_n = 1'b0; cyc(); k_stop_n = 1'b1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         tick = 1'b1; cyc(); tick = 1'b0; cyc();
      end
   endtask

   initial begin
      int led0, en0, n, dmin, dmax;

      cyc(); cyc(); rst = 1'b0; cyc();

      // reset state
      chk("rst_state", state, 0);
      chk("rst_clr", t_clr, 1);
      chk("rst_en", t_en, 0);
      chk("rst_led", led, 0);
      chk("rst_best", best, 16'h9999);
      chk("rst_flags", {new_best, foul, timeout}, 0);

      // 1: two-tick run
      press_start();
      chk("r1_delay", state, 1);
      chk("r1_clr_delay", t_clr, 0);
      ticks(3);
      chk("r1_still_delay", state, 1);
      ticks(1);
      chk("r1_measure", state, 2);
      chk("r1_led", led, 1);
      chk("r1_en", t_en, 1);
      ticks(2);
      chk("r1_tv", timer_val, 16'h0002);
      press_stop();
      chk("r1_result", state, 3);
      chk("r1_led_off", led, 0);
      chk("r1_tv_res", timer_val, 16'h0002);
      cyc(); cyc();
      chk("r1_best", best, 16'h0002);
      chk("r1_new_best", new_best, 1);

      // 2: slower run does not replace best
      press_start();
      chk("r2_idle", state, 0);
      chk("r2_nb_held", new_best, 1);
      cyc();
      press_start();
      chk("r2_nb_clr", new_best, 0);
      ticks(4);
      chk("r2_measure", state, 2);
      ticks(5);
      chk("r2_tv", timer_val, 16'h0005);
      press_stop(); cyc(); cyc();
      chk("r2_best", best, 16'h0002);
      chk("r2_new_best", new_best, 0);
      press_start();
      chk("r2_idle_end", state, 0);
      chk("r2_clr", t_clr, 1);
      cyc();

      // 3: false start, then foul on the same cycle as the final tick
      led0 = led_cnt; en0 = en_cnt;
      press_start();
      ticks(2);
      press_stop();
      chk("f_state", state, 4);
      chk("f_flag", foul, 1);
      chk("f_clr", t_clr, 1);
      cyc();
      chk("f_led_never", led_cnt - led0, 0);
      chk("f_en_never", en_cnt - en0, 0);
      chk("f_best", best, 16'h0002);
      press_start();
      chk("f_idle", state, 0);
      chk("f_held", foul, 1);
      cyc();
      press_start();
      chk("f_clr_flag", foul, 0);
      ticks(3);
      tick = 1'b1; k_stop_n = 1'b0; cyc(); tick = 1'b0; k_stop_n = 1'b1;
      chk("f_tie_state", state, 4);
      cyc();
      press_start(); cyc();

      // 4: timeout, TIMER_VAL drops afterwards to show the compare is suppressed
      press_start();
      ticks(4);
      chk("t_measure", state, 2);
      force_en = 1'b1; force_val = 16'h9999; cyc(); force_en = 1'b0;
      chk("t_result", state, 3);
      chk("t_flag", timeout, 1);
      cyc(); cyc();
      chk("t_best", best, 16'h0002);
      chk("t_nb", new_best, 0);
      press_start(); cyc();
      press_start();
      chk("t_flag_clr", timeout, 0);
      ticks(4);
      force_en = 1'b1; k_stop_n = 1'b0; cyc(); force_en = 1'b0; k_stop_n = 1'b1;
      chk("t2_result", state, 3);
      chk("t2_flag", timeout, 1);
      cyc(); cyc();
      chk("t2_best", best, 16'h0002);
      press_start(); cyc();

      // 5: lock, then reset mid-measure
      sw_lock = 1'b1;
      press_start();
      chk("lock_idle", state, 0);
      cyc();
      chk("lock_idle2", state, 0);
      sw_lock = 1'b0;
      cyc();
      press_start();
      chk("unlock_delay", state, 1);
      ticks(4);
      tick = 1'b1; cyc(); tick = 1'b0;
      chk("m_before_rst", state, 2);
      rst = 1'b1; cyc(); rst = 1'b0;
      chk("mrst_state", state, 0);
      chk("mrst_led", led, 0);
      chk("mrst_best", best, 16'h9999);
      chk("mrst_clr", t_clr, 1);
      chk("mrst_en", t_en, 0);
      cyc();

      // 6: delay range with default parameters
      dmin = 100000; dmax = 0;
      for (int r = 0; r < 40; r++) begin
         for (int w = 0; w < int'($urandom_range(0, 7)); w++) cyc();
         s2_start_n = 1'b0; cyc(); s2_start_n = 1'b1;
         chk("d_enter", state2, 1);
         n = 0;
         while (state2 != 3'd2 && n < 3000) begin
            cyc();
            n++;
         end
         total++;
         assert (n >= 1000 && n <= 2023) else begin
            bad++;
            $error("FAIL delay_range run=%0d observed=%0d expected=1000..2023", r, n);
         end
         total++;
         assert (dut2.u_lfsr.q !== 16'h0000) else begin
            bad++;
            $error("FAIL lfsr_zero run=%0d observed=%0h expected=nonzero", r, dut2.u_lfsr.q);
         end
         if (n < dmin) dmin = n;
         if (n > dmax) dmax = n;
         s2_stop_n = 1'b0; cyc(); s2_stop_n = 1'b1; cyc();
         s2_start_n = 1'b0; cyc(); s2_start_n = 1'b1; cyc();
      end
      total++;
      assert (dmin != dmax) else begin
         bad++;
         $error("FAIL delay_varies observed=min%0d/max%0d expected=distinct", dmin, dmax);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
